// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg -- decode/execute pipeline register of the 5-stage MIPS pipeline.
//
// Captures the decoder control bundle, register-file operands, register
// specifiers, sign-extended immediate and PC+4 on every rising clock edge,
// with hazard-unit hold (StallE) and bubble insertion (FlushE). ValidE marks
// a real instruction in the execute stage; a bubble (ValidE=0) always has
// RegWriteE, MemWriteE and BranchE at 0.
//
// Parameters:
//   DW  datapath width of operands, immediate and PC+4
//   AW  register-specifier width
//   CW  bubble-counter width (only meaningful with IDEX_BUBBLE_CNT_EN)
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   StallE, FlushE       hazard-unit hold / bubble load (flush wins)
//   ValidD               decode stage holds a real instruction
//   *D control inputs    RegWrite, MemtoReg, MemWrite, Branch, ALUSrc,
//                        RegDst (1 bit each), ALUOp (2 bits)
//   RD1D, RD2D           register-file read data
//   RsD, RtD, RdD        register specifiers
//   SignImmD, PCPlus4D   sign-extended immediate, PC+4
//   *E outputs           registered copies of the above, plus ValidE
//   BubbleCnt            saturating count of flush edges
//
// Optional feature macro: IDEX_BUBBLE_CNT_EN
//   defined   -> BubbleCnt is a CW-bit saturating flush counter
//   undefined -> BubbleCnt is tied to 0 and no counter flops exist
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          StallE,
    input  logic          FlushE,
    input  logic          ValidD,
    input  logic          RegWriteD,
    input  logic          MemtoRegD,
    input  logic          MemWriteD,
    input  logic          BranchD,
    input  logic          ALUSrcD,
    input  logic          RegDstD,
    input  logic [1:0]    ALUOpD,
    input  logic [DW-1:0] RD1D,
    input  logic [DW-1:0] RD2D,
    input  logic [AW-1:0] RsD,
    input  logic [AW-1:0] RtD,
    input  logic [AW-1:0] RdD,
    input  logic [DW-1:0] SignImmD,
    input  logic [DW-1:0] PCPlus4D,
    output logic          RegWriteE,
    output logic          MemtoRegE,
    output logic          MemWriteE,
    output logic          BranchE,
    output logic          ALUSrcE,
    output logic          RegDstE,
    output logic [1:0]    ALUOpE,
    output logic [DW-1:0] RD1E,
    output logic [DW-1:0] RD2E,
    output logic [DW-1:0] SignImmE,
    output logic [DW-1:0] PCPlus4E,
    output logic [AW-1:0] RsE,
    output logic [AW-1:0] RtE,
    output logic [AW-1:0] RdE,
    output logic          ValidE,
    output logic [CW-1:0] BubbleCnt
);

    typedef struct packed {
        logic          reg_write;
        logic          memto_reg;
        logic          mem_write;
        logic          branch;
        logic          alu_src;
        logic          reg_dst;
        logic [1:0]    alu_op;
        logic          valid;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] sign_imm;
        logic [DW-1:0] pc_plus4;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
    } stage_t;

    localparam int SW = $bits(stage_t);

    stage_t capture_s;
    stage_t next_s;
    stage_t stage_r;

    // Assemble the decode-side bundle; an invalid instruction carries no
    // control so that a non-instruction can never write, store or branch.
    always_comb begin
        capture_s          = stage_t'({SW{1'b0}});
        capture_s.valid    = ValidD;
        capture_s.rd1      = RD1D;
        capture_s.rd2      = RD2D;
        capture_s.sign_imm = SignImmD;
        capture_s.pc_plus4 = PCPlus4D;
        capture_s.rs       = RsD;
        capture_s.rt       = RtD;
        capture_s.rd       = RdD;
        if (ValidD) begin
            capture_s.reg_write = RegWriteD;
            capture_s.memto_reg = MemtoRegD;
            capture_s.mem_write = MemWriteD;
            capture_s.branch    = BranchD;
            capture_s.alu_src   = ALUSrcD;
            capture_s.reg_dst   = RegDstD;
            capture_s.alu_op    = ALUOpD;
        end else begin
            capture_s.reg_write = 1'b0;
            capture_s.memto_reg = 1'b0;
            capture_s.mem_write = 1'b0;
            capture_s.branch    = 1'b0;
            capture_s.alu_src   = 1'b0;
            capture_s.reg_dst   = 1'b0;
            capture_s.alu_op    = 2'b00;
        end
    end

    // Next-state select: flush beats stall, stall holds, otherwise capture.
    always_comb begin
        next_s = stage_r;
        case ({FlushE, StallE})
            2'b10, 2'b11: next_s = stage_t'({SW{1'b0}});
            2'b01:        next_s = stage_r;
            2'b00:        next_s = capture_s;
            default:      next_s = stage_t'({SW{1'b0}});
        endcase
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= stage_t'({SW{1'b0}});
        end else begin
            stage_r <= next_s;
        end
    end

    assign RegWriteE = stage_r.reg_write;
    assign MemtoRegE = stage_r.memto_reg;
    assign MemWriteE = stage_r.mem_write;
    assign BranchE   = stage_r.branch;
    assign ALUSrcE   = stage_r.alu_src;
    assign RegDstE   = stage_r.reg_dst;
    assign ALUOpE    = stage_r.alu_op;
    assign ValidE    = stage_r.valid;
    assign RD1E      = stage_r.rd1;
    assign RD2E      = stage_r.rd2;
    assign SignImmE  = stage_r.sign_imm;
    assign PCPlus4E  = stage_r.pc_plus4;
    assign RsE       = stage_r.rs;
    assign RtE       = stage_r.rt;
    assign RdE       = stage_r.rd;

`ifdef IDEX_BUBBLE_CNT_EN
    logic [CW-1:0] bubble_cnt_r;

    // Saturating count of flush edges; stall has no influence on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r <= {CW{1'b0}};
        end else if (FlushE && (bubble_cnt_r != {CW{1'b1}})) begin
            bubble_cnt_r <= bubble_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign BubbleCnt = bubble_cnt_r;
`else
    assign BubbleCnt = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg -- directed self-checking bench for id_ex_reg.
// Drives inputs just after the falling edge and samples outputs on the
// following falling edge (one rising edge later). The counter instance uses
// CW=2 so saturation is reached after three flushes.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic          StallE, FlushE, ValidD;
    logic          RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD;
    logic [1:0]    ALUOpD;
    logic [DW-1:0] RD1D, RD2D, SignImmD, PCPlus4D;
    logic [AW-1:0] RsD, RtD, RdD;
    logic          RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE;
    logic [1:0]    ALUOpE;
    logic [DW-1:0] RD1E, RD2E, SignImmE, PCPlus4E;
    logic [AW-1:0] RsE, RtE, RdE;
    logic          ValidE;
    logic [CW-1:0] BubbleCnt;

    int checks;
    int failures;

    id_ex_reg #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
        .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .RegDstD(RegDstD), .ALUOpD(ALUOpD), .RD1D(RD1D), .RD2D(RD2D),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
        .PCPlus4D(PCPlus4D), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .RegDstE(RegDstE), .ALUOpE(ALUOpE), .RD1E(RD1E), .RD2E(RD2E),
        .SignImmE(SignImmE), .PCPlus4E(PCPlus4E), .RsE(RsE), .RtE(RtE),
        .RdE(RdE), .ValidE(ValidE), .BubbleCnt(BubbleCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // OR of every pipeline output (BubbleCnt excluded): 0 only for a clean bubble
    function automatic logic any_out();
        return |{RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE,
                 ALUOpE, ValidE, RD1E, RD2E, SignImmE, PCPlus4E, RsE, RtE, RdE};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_d();
        ValidD = 1'b0; RegWriteD = 1'b0; MemtoRegD = 1'b0; MemWriteD = 1'b0;
        BranchD = 1'b0; ALUSrcD = 1'b0; RegDstD = 1'b0; ALUOpD = 2'b00;
        RD1D = 32'd0; RD2D = 32'd0; SignImmD = 32'd0; PCPlus4D = 32'd0;
        RsD = 5'd0; RtD = 5'd0; RdD = 5'd0;
    endtask

    // one rising edge, then settle on the falling edge for sampling
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        clear_d();

        // reset state
        @(negedge clk);
        chk("reset_outputs_zero", {63'd0, any_out()}, 64'd0);
        chk("reset_bubblecnt", {62'd0, BubbleCnt}, 64'd0);
        rst_n = 1'b1;

        // reset mid-operation, asserted between edges while stalling
        ValidD = 1'b1; RegWriteD = 1'b1; RD1D = 32'h1234_5678;
        step();
        chk("pre_reset_rd1", {32'd0, RD1E}, 64'h1234_5678);
        chk("pre_reset_regwrite", {63'd0, RegWriteE}, 64'd1);
        StallE = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("async_reset_clears", {63'd0, any_out()}, 64'd0);
        step();
        chk("reset_during_stall", {63'd0, any_out()}, 64'd0);
        rst_n = 1'b1;
        StallE = 1'b0;

        // normal capture: lw
        clear_d();
        ValidD = 1'b1; RegWriteD = 1'b1; ALUSrcD = 1'b1; MemtoRegD = 1'b1;
        ALUOpD = 2'b00; SignImmD = 32'h0000_0004; RtD = 5'd5; RsD = 5'd3;
        RD1D = 32'h0000_0100; PCPlus4D = 32'h0000_0010;
        #1 chk("lw_not_yet_valid", {63'd0, ValidE}, 64'd0);
        step();
        chk("lw_valid", {63'd0, ValidE}, 64'd1);
        chk("lw_regwrite", {63'd0, RegWriteE}, 64'd1);
        chk("lw_alusrc", {63'd0, ALUSrcE}, 64'd1);
        chk("lw_memtoreg", {63'd0, MemtoRegE}, 64'd1);
        chk("lw_aluop", {62'd0, ALUOpE}, 64'd0);
        chk("lw_signimm", {32'd0, SignImmE}, 64'd4);
        chk("lw_rt", {59'd0, RtE}, 64'd5);
        chk("lw_rs", {59'd0, RsE}, 64'd3);
        chk("lw_rd1", {32'd0, RD1E}, 64'h100);
        chk("lw_pcplus4", {32'd0, PCPlus4E}, 64'h10);
        chk("lw_memwrite", {63'd0, MemWriteE}, 64'd0);

        // R-type capture, then hold for 3 edges while a store waits at D
        clear_d();
        ValidD = 1'b1; RegWriteD = 1'b1; RegDstD = 1'b1; ALUOpD = 2'b10;
        RdD = 5'd9; RsD = 5'd1; RtD = 5'd2; RD1D = 32'd11; RD2D = 32'd22;
        step();
        chk("rtype_regdst", {63'd0, RegDstE}, 64'd1);
        chk("rtype_aluop", {62'd0, ALUOpE}, 64'd2);
        chk("rtype_rd", {59'd0, RdE}, 64'd9);
        clear_d();
        ValidD = 1'b1; MemWriteD = 1'b1; ALUSrcD = 1'b1; ALUOpD = 2'b00;
        RtD = 5'd7; RsD = 5'd4; SignImmD = 32'd8; RD2D = 32'hCAFE;
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_rd", {59'd0, RdE}, 64'd9);
            chk("stall_regdst", {63'd0, RegDstE}, 64'd1);
            chk("stall_aluop", {62'd0, ALUOpE}, 64'd2);
            chk("stall_memwrite", {63'd0, MemWriteE}, 64'd0);
            chk("stall_rd2", {32'd0, RD2E}, 64'd22);
            chk("stall_valid", {63'd0, ValidE}, 64'd1);
        end
        StallE = 1'b0;
        step();
        chk("store_memwrite", {63'd0, MemWriteE}, 64'd1);
        chk("store_regwrite", {63'd0, RegWriteE}, 64'd0);
        chk("store_rt", {59'd0, RtE}, 64'd7);
        chk("store_signimm", {32'd0, SignImmE}, 64'd8);
        chk("store_rd2", {32'd0, RD2E}, 64'hCAFE);

        // flush over stall with a valid beq at D
        clear_d();
        ValidD = 1'b1; BranchD = 1'b1; ALUOpD = 2'b01; RsD = 5'd4; RtD = 5'd6;
        SignImmD = 32'd3; PCPlus4D = 32'h0000_0040; RD1D = 32'd5; RD2D = 32'd5;
        StallE = 1'b1; FlushE = 1'b1;
        step();
        chk("flush_all_zero", {63'd0, any_out()}, 64'd0);
        chk("flush_valid", {63'd0, ValidE}, 64'd0);
        StallE = 1'b0; FlushE = 1'b0;
        step();
        chk("beq_branch", {63'd0, BranchE}, 64'd1);
        chk("beq_aluop", {62'd0, ALUOpE}, 64'd1);
        chk("beq_pcplus4", {32'd0, PCPlus4E}, 64'h40);
        chk("beq_valid", {63'd0, ValidE}, 64'd1);

        // invalid capture forces the side-effect controls low
        clear_d();
        ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 1'b1; BranchD = 1'b1;
        RD1D = 32'hDEAD_BEEF;
        step();
        chk("inv_valid", {63'd0, ValidE}, 64'd0);
        chk("inv_regwrite", {63'd0, RegWriteE}, 64'd0);
        chk("inv_memwrite", {63'd0, MemWriteE}, 64'd0);
        chk("inv_branch", {63'd0, BranchE}, 64'd0);
        chk("inv_rd1", {32'd0, RD1E}, 64'hDEAD_BEEF);

        // bubble counter: restart from reset, then 5 flush edges (one stalled)
        rst_n = 1'b0;
        #1 chk("cnt_reset", {62'd0, BubbleCnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        FlushE = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            StallE = (i == 2) ? 1'b1 : 1'b0;
            step();
`ifdef IDEX_BUBBLE_CNT_EN
            chk("bubble_cnt", {62'd0, BubbleCnt}, (i >= 3) ? 64'd3 : 64'(i));
`else
            chk("bubble_cnt_tied", {62'd0, BubbleCnt}, 64'd0);
`endif
            chk("bubble_outputs_zero", {63'd0, any_out()}, 64'd0);
        end
        FlushE = 1'b0;
        StallE = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
